// File: rtl/proc_mem_responder_if.sv
// Request/response bus between a processor-side requester and a memory responder.
interface proc_mem_responder_if;
  logic        memreq_val;
  logic        memreq_rdy;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_data;
  logic        memresp_val;
  logic        memresp_rdy;
  logic [31:0] memresp_data;

  modport master (
    output memreq_val, memreq_type, memreq_addr, memreq_data, memresp_rdy,
    input  memreq_rdy, memresp_val, memresp_data
  );

  modport slave (
    input  memreq_val, memreq_type, memreq_addr, memreq_data, memresp_rdy,
    output memreq_rdy, memresp_val, memresp_data
  );
endinterface

// File: rtl/proc_mem_responder.sv
// Word-addressed memory responder with a 2-entry in-order response queue.
// Reads sample the array when accepted; writes update it at the accepting edge.
// Each queued response waits LATENCY-1 cycles before it is offered.
// Misaligned or out-of-range requests raise a sticky error and answer with data 0.
module proc_mem_responder #(
  parameter int WORDS   = 256,
  parameter int LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  proc_mem_responder_if.slave  bus,
  output logic                 mem_err
);

  localparam int         IDX_W    = $clog2(WORDS);
  localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

  logic [31:0]      mem_array [WORDS];

  logic [1:0]       occupancy;
  logic             head;
  logic [31:0]      entry_data [2];
  logic [1:0]       entry_cnt  [2];

  logic             accept;
  logic             deliver;
  logic             illegal;
  logic             tail;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      resp_capture;

  assign word_idx = bus.memreq_addr[IDX_W+1:2];
  assign illegal  = (bus.memreq_addr[1:0] != 2'b00) || (|bus.memreq_addr[31:IDX_W+2]);

  // Ready only depends on queue occupancy (and is held low while in reset).
  assign bus.memreq_rdy   = rst && (occupancy < 2'd2);
  assign bus.memresp_val  = (occupancy != 2'd0) && (entry_cnt[head] == 2'd0);
  assign bus.memresp_data = bus.memresp_val ? entry_data[head] : 32'h0;

  assign accept  = bus.memreq_val && bus.memreq_rdy;
  assign deliver = bus.memresp_val && bus.memresp_rdy;

  // Next free slot: the head slot when empty, the other slot when one entry is held.
  assign tail = head ^ occupancy[0];

  // Writes and illegal requests answer with zero; reads snapshot the array now.
  assign resp_capture = (bus.memreq_type || illegal) ? 32'h0 : mem_array[word_idx];

  // Storage array: deliberately not reset, written only by legal accepted writes.
  always_ff @(posedge clk) begin
    if (accept && bus.memreq_type && !illegal) begin
      mem_array[word_idx] <= bus.memreq_data;
    end
  end

  // Response queue bookkeeping, countdowns and the sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy  <= 2'd0;
      head       <= 1'b0;
      entry_data <= '{default: 32'h0};
      entry_cnt  <= '{default: 2'd0};
      mem_err    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (entry_cnt[i] != 2'd0) begin
          entry_cnt[i] <= entry_cnt[i] - 2'd1;
        end
      end
      if (accept) begin
        entry_cnt[tail]  <= CNT_LOAD;
        entry_data[tail] <= resp_capture;
      end
      if (deliver) begin
        head <= ~head;
      end
      case ({accept, deliver})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
      if (accept && illegal) begin
        mem_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_proc_mem_responder.sv
// Scoreboard bench for proc_mem_responder: one instance with LATENCY=1 and one
// with LATENCY=3, sharing clock and reset.
module tb_proc_mem_responder;

  logic clk = 1'b0;
  logic rst;
  logic err_a;
  logic err_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];

  proc_mem_responder_if if_a ();
  proc_mem_responder_if if_b ();

  proc_mem_responder #(.WORDS(256), .LATENCY(1)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (if_a.slave),
    .mem_err (err_a)
  );

  proc_mem_responder #(.WORDS(256), .LATENCY(3)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .bus     (if_b.slave),
    .mem_err (err_b)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, required);
    end
  endtask

  task automatic set_req(input int k, input logic val, input logic typ,
                         input logic [31:0] addr, input logic [31:0] data);
    if (k == 0) begin
      if_a.memreq_val  = val;
      if_a.memreq_type = typ;
      if_a.memreq_addr = addr;
      if_a.memreq_data = data;
    end else begin
      if_b.memreq_val  = val;
      if_b.memreq_type = typ;
      if_b.memreq_addr = addr;
      if_b.memreq_data = data;
    end
  endtask

  // Present one request, wait (bounded) for acceptance, record its expected response.
  task automatic apply_stimulus(input int k, input logic typ, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] expected);
    int   waited;
    logic rdy;
    waited = 0;
    set_req(k, 1'b1, typ, addr, data);
    @(negedge clk);
    rdy = (k == 0) ? if_a.memreq_rdy : if_b.memreq_rdy;
    while (!rdy && waited < 50) begin
      waited++;
      @(negedge clk);
      rdy = (k == 0) ? if_a.memreq_rdy : if_b.memreq_rdy;
    end
    if (!rdy) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: inst %0d addr %h never accepted", k, addr);
    end else if (k == 0) begin
      exp_a.push_back(expected);
    end else begin
      exp_b.push_back(expected);
    end
    @(posedge clk);
    #1;
    set_req(k, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Wait (bounded) until every expected response of an instance has been seen.
  task automatic drain(input int k);
    int n;
    n = 0;
    while (((k == 0) ? exp_a.size() : exp_b.size()) != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (((k == 0) ? exp_a.size() : exp_b.size()) != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: inst %0d pending %0d expected 0", k,
               (k == 0) ? exp_a.size() : exp_b.size());
    end
  endtask

  // Monitor: compare each delivered response against the scoreboard queue.
  always @(negedge clk) begin
    if (if_a.memresp_val) begin
      if (exp_a.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_resp_a: got data %h expected no response", if_a.memresp_data);
      end else if (if_a.memresp_rdy) begin
        check_output("resp_a", if_a.memresp_data, exp_a.pop_front());
      end
    end else begin
      check_output("idle_data_a", if_a.memresp_data, 32'h0);
    end
    if (if_b.memresp_val) begin
      if (exp_b.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_resp_b: got data %h expected no response", if_b.memresp_data);
      end else if (if_b.memresp_rdy) begin
        check_output("resp_b", if_b.memresp_data, exp_b.pop_front());
      end
    end else begin
      check_output("idle_data_b", if_b.memresp_data, 32'h0);
    end
  end

  // Hard stop in case anything stalls forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    if_a.memresp_rdy = 1'b1;
    if_b.memresp_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_req_rdy_a", 32'(if_a.memreq_rdy), 32'h0);
    check_output("rst_resp_val_a", 32'(if_a.memresp_val), 32'h0);
    check_output("rst_err_a", 32'(err_a), 32'h0);
    check_output("rst_req_rdy_b", 32'(if_b.memreq_rdy), 32'h0);
    check_output("rst_resp_val_b", 32'(if_b.memresp_val), 32'h0);
    rst = 1'b1;
    #1;
    check_output("post_rst_rdy_a", 32'(if_a.memreq_rdy), 32'h1);
    check_output("post_rst_rdy_b", 32'(if_b.memreq_rdy), 32'h1);
    @(posedge clk);
    #1;

    // LATENCY=1: write then read of the same word, each answered one cycle later.
    apply_stimulus(0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    check_output("lat1_write_resp_val", 32'(if_a.memresp_val), 32'h1);
    @(posedge clk);
    #1;
    apply_stimulus(0, 1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    check_output("lat1_read_resp_val", 32'(if_a.memresp_val), 32'h1);
    @(posedge clk);
    #1;

    // Read captured before a write accepted on the next cycle.
    apply_stimulus(0, 1'b1, 32'h0000_0008, 32'hAAAA_5555, 32'h0);
    apply_stimulus(0, 1'b0, 32'h0000_0008, 32'h0, 32'hAAAA_5555);
    apply_stimulus(0, 1'b1, 32'h0000_0008, 32'h1111_1111, 32'h0);
    apply_stimulus(0, 1'b0, 32'h0000_0008, 32'h0, 32'h1111_1111);
    drain(0);

    // Illegal requests: misaligned read and out-of-range write.
    apply_stimulus(0, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0);
    drain(0);
    check_output("err_before_illegal", 32'(err_a), 32'h0);
    apply_stimulus(0, 1'b0, 32'h0000_0002, 32'h0, 32'h0);
    check_output("err_after_misaligned", 32'(err_a), 32'h1);
    apply_stimulus(0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0);
    apply_stimulus(0, 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678);
    drain(0);
    check_output("err_sticky", 32'(err_a), 32'h1);

    // LATENCY=3: preload two words.
    apply_stimulus(1, 1'b1, 32'h0000_0010, 32'hA1A1_A1A1, 32'h0);
    apply_stimulus(1, 1'b1, 32'h0000_0014, 32'hB2B2_B2B2, 32'h0);
    drain(1);

    // Fill the queue with responses blocked.
    if_b.memresp_rdy = 1'b0;
    apply_stimulus(1, 1'b0, 32'h0000_0010, 32'h0, 32'hA1A1_A1A1);
    apply_stimulus(1, 1'b0, 32'h0000_0014, 32'h0, 32'hB2B2_B2B2);
    check_output("full_req_rdy", 32'(if_b.memreq_rdy), 32'h0);
    @(negedge clk);
    check_output("lat3_not_early", 32'(if_b.memresp_val), 32'h0);
    @(negedge clk);
    check_output("lat3_head_ready", 32'(if_b.memresp_val), 32'h1);
    @(posedge clk);
    #1;
    // Full queue: deliver and request in the same cycle, request must wait.
    set_req(1, 1'b1, 1'b0, 32'h0000_0014, 32'h0);
    if_b.memresp_rdy = 1'b1;
    @(negedge clk);
    check_output("full_no_accept_on_deliver", 32'(if_b.memreq_rdy), 32'h0);
    @(posedge clk);
    #1;
    check_output("rdy_returns", 32'(if_b.memreq_rdy), 32'h1);
    apply_stimulus(1, 1'b0, 32'h0000_0014, 32'h0, 32'hB2B2_B2B2);
    drain(1);

    // Reset with two pending responses.
    apply_stimulus(1, 1'b0, 32'h0000_0003, 32'h0, 32'h0);
    drain(1);
    check_output("err_b_set", 32'(err_b), 32'h1);
    if_b.memresp_rdy = 1'b0;
    apply_stimulus(1, 1'b0, 32'h0000_0010, 32'h0, 32'hA1A1_A1A1);
    apply_stimulus(1, 1'b0, 32'h0000_0014, 32'h0, 32'hB2B2_B2B2);
    repeat (3) @(posedge clk);
    #1;
    check_output("pending_before_reset", 32'(if_b.memresp_val), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    exp_b.delete();
    check_output("reset_resp_val", 32'(if_b.memresp_val), 32'h0);
    check_output("reset_resp_data", if_b.memresp_data, 32'h0);
    check_output("reset_req_rdy", 32'(if_b.memreq_rdy), 32'h0);
    check_output("reset_err_b", 32'(err_b), 32'h0);
    check_output("reset_err_a", 32'(err_a), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    if_b.memresp_rdy = 1'b1;
    #1;
    check_output("release_req_rdy", 32'(if_b.memreq_rdy), 32'h1);
    repeat (10) @(posedge clk);
    #1;
    apply_stimulus(1, 1'b0, 32'h0000_0010, 32'h0, 32'hA1A1_A1A1);
    drain(1);

    repeat (3) @(posedge clk);
    #1;
    check_output("leftover_a", 32'(exp_a.size()), 32'h0);
    check_output("leftover_b", 32'(exp_b.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
